// File: rtl/vlane_pkg.sv
// vlane_pkg
// Shared constants and types for the vector lane sequencer.
//   - default register-code width, vector length and lane count
//   - derived width constants for the defaults
//   - sequencer state encoding
package vlane_pkg;

  localparam int CODE_W_DEF = 5;
  localparam int VLEN_DEF   = 8;
  localparam int LANES_DEF  = 2;

  localparam int IDX_W_DEF  = CODE_W_DEF - 1;
  localparam int ELEM_W_DEF = $clog2(VLEN_DEF);
  localparam int VL_W_DEF   = $clog2(VLEN_DEF) + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/lane_code_decode.sv
// lane_code_decode
// Splits a register code into a vector-register flag (code MSB) and a
// register index (remaining low bits). Purely combinational.
//   code_i  in   CODE_W    register code
//   vec_o   out  1         1 = vector register, 0 = scalar register
//   idx_o   out  CODE_W-1  register number
module lane_code_decode
  import vlane_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic [CODE_W-1:0] code_i,
  output logic              vec_o,
  output logic [CODE_W-2:0] idx_o
);

  assign vec_o = code_i[CODE_W-1];
  assign idx_o = code_i[CODE_W-2:0];

endmodule

// File: rtl/vector_lane_sequencer.sv
// vector_lane_sequencer
// Accepts one instruction at a time and issues it as a series of beats of
// LANES elements each, with a per-lane enable mask for the ragged tail.
//   clk, rst                       clock, async active-high reset
//   in_valid / in_ready            instruction handshake
//   in_rd, in_rs1, in_rs2          operand register codes
//   in_vl                          requested vector length
//   out_valid / out_ready          beat handshake
//   out_{rd,rs1,rs2}_vec / _idx    decoded operands
//   out_elem, out_lane_en          first element of beat, active-lane mask
//   out_first, out_last            beat position within the instruction
//   err                            one-cycle pulse on illegal vector length
module vector_lane_sequencer
  import vlane_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int VLEN   = VLEN_DEF,
  parameter int LANES  = LANES_DEF,
  localparam int IDX_W  = CODE_W - 1,
  localparam int ELEM_W = $clog2(VLEN),
  localparam int VL_W   = $clog2(VLEN) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_rd,
  input  logic [CODE_W-1:0] in_rs1,
  input  logic [CODE_W-1:0] in_rs2,
  input  logic [VL_W-1:0]   in_vl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_rd_vec,
  output logic              out_rs1_vec,
  output logic              out_rs2_vec,
  output logic [IDX_W-1:0]  out_rd_idx,
  output logic [IDX_W-1:0]  out_rs1_idx,
  output logic [IDX_W-1:0]  out_rs2_idx,
  output logic [ELEM_W-1:0] out_elem,
  output logic [LANES-1:0]  out_lane_en,
  output logic              out_first,
  output logic              out_last,
  output logic              err
);

  localparam int LANE_SH = $clog2(LANES);
  localparam logic [VL_W-1:0] VLEN_V  = VL_W'(VLEN);
  localparam logic [VL_W:0]   LANES_X = (VL_W + 1)'(LANES);

  state_e            state_q, state_d;
  logic [ELEM_W-1:0] beat_q, beat_d;
  logic [VL_W-1:0]   vl_q, vl_d;
  logic              rd_vec_q, rs1_vec_q, rs2_vec_q;
  logic              rd_vec_d, rs1_vec_d, rs2_vec_d;
  logic [IDX_W-1:0]  rd_idx_q, rs1_idx_q, rs2_idx_q;
  logic [IDX_W-1:0]  rd_idx_d, rs1_idx_d, rs2_idx_d;
  logic              err_q, err_d;

  logic              dec_rd_vec, dec_rs1_vec, dec_rs2_vec;
  logic [IDX_W-1:0]  dec_rd_idx, dec_rs1_idx, dec_rs2_idx;

  lane_code_decode #(.CODE_W(CODE_W)) u_dec_rd (
    .code_i (in_rd),
    .vec_o  (dec_rd_vec),
    .idx_o  (dec_rd_idx)
  );

  lane_code_decode #(.CODE_W(CODE_W)) u_dec_rs1 (
    .code_i (in_rs1),
    .vec_o  (dec_rs1_vec),
    .idx_o  (dec_rs1_idx)
  );

  lane_code_decode #(.CODE_W(CODE_W)) u_dec_rs2 (
    .code_i (in_rs2),
    .vec_o  (dec_rs2_vec),
    .idx_o  (dec_rs2_idx)
  );

  // in_ready is masked by rst so nothing is accepted while reset is held.
  logic            accept;
  logic            any_vec;
  logic            vl_zero;
  logic            vl_big;
  logic [VL_W-1:0] vl_eff;

  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign any_vec  = dec_rd_vec || dec_rs1_vec || dec_rs2_vec;
  assign vl_zero  = (in_vl == '0);
  assign vl_big   = (in_vl > VLEN_V);

  // A scalar instruction is issued as a one-element vector so the beat
  // logic below needs no special case.
  always_comb begin
    vl_eff = in_vl;
    if (!any_vec) begin
      vl_eff = VL_W'(1);
    end else if (vl_big) begin
      vl_eff = VLEN_V;
    end
  end

  logic [ELEM_W-1:0] elem;
  logic [VL_W:0]     elem_x;
  logic              last_beat;

  assign elem      = beat_q << LANE_SH;
  assign elem_x    = {2'b00, elem};
  assign last_beat = (elem_x + LANES_X) >= {1'b0, vl_q};

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    vl_d      = vl_q;
    rd_vec_d  = rd_vec_q;
    rs1_vec_d = rs1_vec_q;
    rs2_vec_d = rs2_vec_q;
    rd_idx_d  = rd_idx_q;
    rs1_idx_d = rs1_idx_q;
    rs2_idx_d = rs2_idx_q;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          err_d = any_vec && (vl_zero || vl_big);
          // A zero-length vector instruction is consumed without issuing.
          if (!(any_vec && vl_zero)) begin
            state_d   = ST_ISSUE;
            beat_d    = '0;
            vl_d      = vl_eff;
            rd_vec_d  = dec_rd_vec;
            rs1_vec_d = dec_rs1_vec;
            rs2_vec_d = dec_rs2_vec;
            rd_idx_d  = dec_rd_idx;
            rs1_idx_d = dec_rs1_idx;
            rs2_idx_d = dec_rs2_idx;
          end
        end
      end
      ST_ISSUE: begin
        if (out_ready) begin
          if (last_beat) begin
            state_d = ST_IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + ELEM_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      vl_q      <= '0;
      rd_vec_q  <= 1'b0;
      rs1_vec_q <= 1'b0;
      rs2_vec_q <= 1'b0;
      rd_idx_q  <= '0;
      rs1_idx_q <= '0;
      rs2_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      vl_q      <= vl_d;
      rd_vec_q  <= rd_vec_d;
      rs1_vec_q <= rs1_vec_d;
      rs2_vec_q <= rs2_vec_d;
      rd_idx_q  <= rd_idx_d;
      rs1_idx_q <= rs1_idx_d;
      rs2_idx_q <= rs2_idx_d;
      err_q     <= err_d;
    end
  end

  // Lane i is live when its element index is still below the vector length.
  always_comb begin
    out_lane_en = '0;
    for (int i = 0; i < LANES; i++) begin
      out_lane_en[i] = (elem_x + (VL_W + 1)'(i)) < {1'b0, vl_q};
    end
  end

  assign out_valid   = (state_q == ST_ISSUE);
  assign out_elem    = elem;
  assign out_first   = out_valid && (beat_q == '0);
  assign out_last    = out_valid && last_beat;
  assign out_rd_vec  = rd_vec_q;
  assign out_rs1_vec = rs1_vec_q;
  assign out_rs2_vec = rs2_vec_q;
  assign out_rd_idx  = rd_idx_q;
  assign out_rs1_idx = rs1_idx_q;
  assign out_rs2_idx = rs2_idx_q;
  assign err         = err_q;

endmodule
